kth_largest_select: RTL and testbench

//   Parametrised rank selector: returns the K-th largest of N_IN unsigned WIDTH-bit values.
//   K is chosen per transaction; K=1 gives the max, K=N_IN gives the min.

---
 rtl/kth_largest_select_if.sv | 27 ++
 rtl/kth_largest_select.sv | 116 +++++++++++
 tb/tb_kth_largest_select.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kth_largest_select_if.sv
// Handshake bundle for kth_largest_select: input transaction (values + rank) and result channel.
// RANK_W is derived here so that the bench and the block agree on the rank width.
interface kth_largest_select_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned RANK_W = $clog2(N_IN) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [N_IN*WIDTH-1:0]   in_data;
  logic [RANK_W-1:0]       in_rank;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_rank_err;

  modport slave (
    input  in_valid, in_data, in_rank, out_ready,
    output in_ready, out_valid, out_data, out_rank_err
  );

  modport master (
    output in_valid, in_data, in_rank, out_ready,
    input  in_ready, out_valid, out_data, out_rank_err
  );
endinterface

// File: rtl/kth_largest_select.sv
// Returns the K-th largest of N_IN unsigned values by MSB-first radix selection,
// resolving one result bit per clock between valid/ready handshakes.
module kth_largest_select #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  kth_largest_select_if.slave bus
);
  localparam int unsigned RANK_W = $clog2(N_IN) + 1;
  localparam int unsigned BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                     state_q, state_d;
  logic [N_IN-1:0][WIDTH-1:0] vals_q, vals_d;
  logic [N_IN-1:0]            cand_q, cand_d;
  logic [RANK_W-1:0]          rem_q, rem_d;
  logic [BIT_W-1:0]           bit_q, bit_d;
  logic [WIDTH-1:0]           res_q, res_d;
  logic                       err_q, err_d;

  logic [N_IN-1:0]            col;
  logic [RANK_W-1:0]          ones;

  // Column of the current bit across all values, and how many live candidates have it set.
  always_comb begin
    col  = '0;
    ones = '0;
    for (int i = 0; i < N_IN; i++) begin
      col[i] = vals_q[i][bit_q];
      ones   = ones + RANK_W'(col[i] & cand_q[i]);
    end
  end

  always_comb begin
    state_d = state_q;
    vals_d  = vals_q;
    cand_d  = cand_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          vals_d = bus.in_data;
          cand_d = '1;
          bit_d  = BIT_W'(WIDTH - 1);
          res_d  = '0;
          if (bus.in_rank == '0) begin
            rem_d = RANK_W'(1);
            err_d = 1'b1;
          end else if (bus.in_rank > RANK_W'(N_IN)) begin
            rem_d = RANK_W'(N_IN);
            err_d = 1'b1;
          end else begin
            rem_d = bus.in_rank;
            err_d = 1'b0;
          end
          state_d = StScan;
        end
      end
      StScan: begin
        // Enough candidates have a 1 here: the answer lies among them. Otherwise they all
        // outrank the answer, so skip past them.
        if (ones >= rem_q) begin
          res_d[bit_q] = 1'b1;
          cand_d       = cand_q & col;
        end else begin
          res_d[bit_q] = 1'b0;
          rem_d        = rem_q - ones;
          cand_d       = cand_q & ~col;
        end
        if (bit_q == '0) begin
          state_d = StDone;
        end else begin
          bit_d = bit_q - BIT_W'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vals_q  <= '0;
      cand_q  <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vals_q  <= vals_d;
      cand_q  <= cand_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.out_valid    = (state_q == StDone);
  assign bus.out_data     = res_q;
  assign bus.out_rank_err = err_q;

endmodule

// File: tb/tb_kth_largest_select.sv
// Bench for kth_largest_select: directed 4x4 vectors with literal expectations, plus
// 500 random back-to-back 8x8 transactions scored against a sort-based model.
module tb_kth_largest_select;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kth_largest_select_if #(.N_IN(4), .WIDTH(4)) ifa ();
  kth_largest_select_if #(.N_IN(8), .WIDTH(8)) ifb ();

  kth_largest_select #(.N_IN(4), .WIDTH(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  kth_largest_select #(.N_IN(8), .WIDTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: sort descending, clamp K, index.
  function automatic int kth_model(input logic [63:0] d, input int n, input int w, input int k);
    int q[$];
    int kk;
    for (int i = 0; i < n; i++) q.push_back(int'((d >> (i * w)) & ((64'd1 << w) - 64'd1)));
    q.rsort();
    kk = (k < 1) ? 1 : ((k > n) ? n : k);
    return q[kk-1];
  endfunction

  function automatic int err_model(input int n, input int k);
    return (k == 0 || k > n) ? 1 : 0;
  endfunction

  function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
    return {d[3:0], c[3:0], b[3:0], a[3:0]};
  endfunction

  // Scoreboards: expected results queued at accept, checked every cycle out_valid is high.
  int qa_d[$], qa_e[$], qa_t[$];
  int qb_d[$], qb_e[$], qb_t[$];
  bit pva = 0, pvb = 0;
  bit thr_on = 0;
  int last_b = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      qa_d.delete(); qa_e.delete(); qa_t.delete();
      pva = 0;
    end else begin
      if (ifa.in_valid && ifa.in_ready) begin
        qa_d.push_back(kth_model(64'(ifa.in_data), 4, 4, int'(ifa.in_rank)));
        qa_e.push_back(err_model(4, int'(ifa.in_rank)));
        qa_t.push_back(cyc + 1);
      end
      if (ifa.out_valid) begin
        if (qa_d.size() == 0) begin
          check("a_spurious_out", 1, 0);
        end else begin
          check("a_out_data", 64'(ifa.out_data), 64'(qa_d[0]));
          check("a_out_err", 64'(ifa.out_rank_err), 64'(qa_e[0]));
          check("a_in_ready_busy", 64'(ifa.in_ready), 0);
          if (!pva) check("a_latency", 64'(cyc - qa_t[0]), 4);
          if (ifa.out_ready) begin
            void'(qa_d.pop_front()); void'(qa_e.pop_front()); void'(qa_t.pop_front());
          end
        end
      end
      pva = ifa.out_valid;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      qb_d.delete(); qb_e.delete(); qb_t.delete();
      pvb = 0;
    end else begin
      if (ifb.in_valid && ifb.in_ready) begin
        qb_d.push_back(kth_model(ifb.in_data, 8, 8, int'(ifb.in_rank)));
        qb_e.push_back(err_model(8, int'(ifb.in_rank)));
        qb_t.push_back(cyc + 1);
        if (thr_on && last_b >= 0) check("b_throughput", 64'(cyc + 1 - last_b), 10);
        last_b = cyc + 1;
      end
      if (ifb.out_valid) begin
        if (qb_d.size() == 0) begin
          check("b_spurious_out", 1, 0);
        end else begin
          check("b_out_data", 64'(ifb.out_data), 64'(qb_d[0]));
          check("b_out_err", 64'(ifb.out_rank_err), 64'(qb_e[0]));
          if (!pvb) check("b_latency", 64'(cyc - qb_t[0]), 8);
          if (ifb.out_ready) begin
            void'(qb_d.pop_front()); void'(qb_e.pop_front()); void'(qb_t.pop_front());
          end
        end
      end
      pvb = ifb.out_valid;
    end
  end

  // Presents a transaction and returns just after the accepting edge with in_valid dropped.
  task automatic send_a(input logic [15:0] d, input logic [2:0] k);
    int n = 0;
    ifa.in_data  = d;
    ifa.in_rank  = k;
    ifa.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.in_ready && n < 40);
    if (!ifa.in_ready) check("a_accept_timeout", 0, 1);
    @(posedge clk);
    #1 ifa.in_valid = 1'b0;
  endtask

  task automatic wait_out_a(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifa.out_valid && n < 12);
    ok = ifa.out_valid;
    if (!ok) check("a_out_timeout", 0, 1);
  endtask

  task automatic run_a(input logic [15:0] d, input logic [2:0] k, input int exp, input int exp_err);
    bit ok;
    check("a_model_pin", 64'(kth_model(64'(d), 4, 4, int'(k))), 64'(exp));
    send_a(d, k);
    wait_out_a(ok);
    if (ok) begin
      check("a_lit_data", 64'(ifa.out_data), 64'(exp));
      check("a_lit_err", 64'(ifa.out_rank_err), 64'(exp_err));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [63:0] d, input logic [3:0] k);
    int n = 0;
    ifb.in_data  = d;
    ifb.in_rank  = k;
    ifb.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!ifb.in_ready && n < 40);
    if (!ifb.in_ready) check("b_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [63:0] rd;
    logic [7:0]  rv;
    int n;
    rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_rank = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_rank = '0; ifb.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(ifa.in_ready), 1);
    check("rst_out_valid", 64'(ifa.out_valid), 0);
    check("rst_out_data", 64'(ifa.out_data), 0);
    check("rst_out_err", 64'(ifa.out_rank_err), 0);
    check("rst_b_out_valid", 64'(ifb.out_valid), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_a(pack4(9, 3, 12, 5), 3'd2, 9, 0);
    run_a(pack4(7, 7, 2, 1), 3'd2, 7, 0);
    run_a(pack4(7, 7, 2, 1), 3'd3, 2, 0);
    run_a(pack4(0, 15, 8, 8), 3'd1, 15, 0);
    run_a(pack4(0, 15, 8, 8), 3'd3, 8, 0);
    run_a(pack4(0, 15, 8, 8), 3'd4, 0, 0);
    run_a(pack4(9, 3, 12, 5), 3'd0, 12, 1);
    run_a(pack4(9, 3, 12, 5), 3'd7, 3, 1);
    run_a(pack4(9, 3, 12, 5), 3'd4, 3, 0);

    // Backpressure: result must hold while stray in_valid pulses are ignored.
    ifa.out_ready = 1'b0;
    send_a(pack4(9, 3, 12, 5), 3'd2);
    wait_out_a(ok);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      ifa.in_valid = i[0] ? 1'b0 : 1'b1;
      ifa.in_data  = pack4(1, 1, 1, 1);
      ifa.in_rank  = 3'd1;
      @(negedge clk);
      check("bp_in_ready", 64'(ifa.in_ready), 0);
      check("bp_out_valid", 64'(ifa.out_valid), 1);
      check("bp_out_data", 64'(ifa.out_data), 9);
    end
    @(posedge clk);
    #1;
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 64'(ifa.out_valid), 0);
    check("bp_release_ready", 64'(ifa.in_ready), 1);

    // Reset while resolving bit 2 of a rank-error transaction.
    send_a(pack4(9, 3, 12, 5), 3'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(ifa.out_valid), 0);
    check("mid_rst_out_data", 64'(ifa.out_data), 0);
    check("mid_rst_out_err", 64'(ifa.out_rank_err), 0);
    check("mid_rst_in_ready", 64'(ifa.in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_a(pack4(9, 3, 12, 5), 3'd1, 12, 0);
    check("a_queue_drained", 64'(qa_d.size()), 0);

    // Random 8x8 traffic, back to back, with duplicate-heavy values mixed in.
    thr_on = 1'b1;
    last_b = -1;
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < 8; i++) begin
        rv = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
        rd[i*8 +: 8] = rv;
      end
      send_b(rd, 4'($urandom_range(0, 10)));
    end
    ifb.in_valid = 1'b0;
    thr_on = 1'b0;
    n = 0;
    while (qb_d.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("b_queue_drained", 64'(qb_d.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
